// File: rtl/intc_nested.sv
// Nested, prioritised interrupt controller with an EPC/level stack and a
// CP0-style register file (EPC, STATUS, PENDING, {sp, level}).
module intc_nested #(
  parameter int unsigned NCH          = 3,
  parameter int unsigned DEPTH        = 4,
  parameter logic [31:0] ENTRY_BASE   = 32'h0000_0cdc,
  parameter logic [31:0] ENTRY_STRIDE = 32'h0000_0031
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NCH-1:0]             irq,
  input  logic                       eret,
  input  logic [31:0]                npc,
  input  logic                       mtc0,
  input  logic                       mfc0,
  input  logic [1:0]                 c0_addr,
  input  logic [31:0]                c0_wdata,
  output logic [31:0]                c0_rdata,
  output logic                       interrupt,
  output logic [31:0]                entry,
  output logic [31:0]                epc,
  output logic [$clog2(NCH+1)-1:0]   level,
  output logic [NCH-1:0]             pending
);

  localparam int unsigned LW  = $clog2(NCH + 1);
  localparam int unsigned SPW = $clog2(DEPTH + 1);
  localparam int unsigned IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  localparam logic [1:0] C0_EPC     = 2'd0;
  localparam logic [1:0] C0_STATUS  = 2'd1;
  localparam logic [1:0] C0_PENDING = 2'd2;
  localparam logic [1:0] C0_STACK   = 2'd3;

  typedef struct packed {
    logic [31:0]   pc;
    logic [LW-1:0] lvl;
  } frame_t;

  // Architectural state
  logic [NCH-1:0] pend_q;
  logic [NCH-1:0] irq_q;
  logic [NCH-1:0] mask_q;
  logic           ie_q;
  logic [LW-1:0]  level_q;
  logic [SPW-1:0] sp_q;
  frame_t         stk_q [DEPTH];

  // Next-state values
  logic [NCH-1:0] pend_d;
  logic [NCH-1:0] mask_d;
  logic           ie_d;
  logic [LW-1:0]  level_d;
  logic [SPW-1:0] sp_d;
  logic           push;
  logic           pop;
  logic           epc_wr;
  logic [NCH-1:0] clr;

  // Arbitration and stack-top views
  logic [LW-1:0]  cand;
  logic           cand_vld;
  logic [LW-1:0]  cand_lvl;
  logic [NCH-1:0] rise;
  logic           stk_nonempty;
  logic [IW-1:0]  top_idx;
  logic [IW-1:0]  push_idx;
  frame_t         top;

  assign rise         = irq & ~irq_q;
  assign stk_nonempty = (sp_q != '0);
  assign top_idx      = stk_nonempty ? IW'(sp_q - SPW'(1)) : '0;
  assign push_idx     = IW'(sp_q);
  assign top          = stk_q[top_idx];

  // Highest-index pending, unmasked channel wins
  always_comb begin
    cand     = '0;
    cand_vld = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (pend_q[i] && mask_q[i]) begin
        cand     = LW'(i);
        cand_vld = 1'b1;
      end
    end
  end

  assign cand_lvl = cand + LW'(1);

  // eret has priority over a take; a full stack or reset blocks any take
  assign interrupt = cand_vld & ie_q & (cand_lvl > level_q) & (sp_q < SP_FULL)
                   & ~eret & ~rst;

  assign epc   = stk_nonempty ? top.pc : '0;
  assign entry = interrupt ? (ENTRY_BASE + 32'(cand) * ENTRY_STRIDE)
               : (eret ? epc : '0);

  assign level   = level_q;
  assign pending = pend_q;

  always_comb begin
    pend_d  = pend_q;
    mask_d  = mask_q;
    ie_d    = ie_q;
    level_d = level_q;
    sp_d    = sp_q;
    push    = 1'b0;
    pop     = 1'b0;
    epc_wr  = 1'b0;
    clr     = '0;

    if (interrupt) begin
      push    = 1'b1;
      sp_d    = sp_q + SPW'(1);
      level_d = cand_lvl;
      clr     = NCH'(1) << cand;
    end else if (eret && stk_nonempty) begin
      pop     = 1'b1;
      sp_d    = sp_q - SPW'(1);
      level_d = top.lvl;
    end

    // A CP0 EPC write only lands when the stack is not moving this cycle
    if (mtc0) begin
      case (c0_addr)
        C0_EPC:     epc_wr = stk_nonempty & ~push & ~pop;
        C0_STATUS: begin
          ie_d   = c0_wdata[0];
          mask_d = c0_wdata[NCH:1];
        end
        C0_PENDING: clr = clr | c0_wdata[NCH-1:0];
        default: ;
      endcase
    end

    // A same-cycle rising edge beats any clear
    pend_d = (pend_q & ~clr) | rise;
  end

  always_comb begin
    c0_rdata = '0;
    if (mfc0) begin
      case (c0_addr)
        C0_EPC:     c0_rdata = epc;
        C0_STATUS:  c0_rdata = 32'({mask_q, ie_q});
        C0_PENDING: c0_rdata = 32'(pend_q);
        C0_STACK:   c0_rdata = {16'h0000, 8'(sp_q), 8'(level_q)};
        default:    c0_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= '0;
      irq_q   <= '0;
      mask_q  <= '1;
      ie_q    <= 1'b1;
      level_q <= '0;
      sp_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        stk_q[i] <= '0;
      end
    end else begin
      irq_q   <= irq;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      ie_q    <= ie_d;
      level_q <= level_d;
      sp_q    <= sp_d;
      if (push) begin
        stk_q[push_idx] <= {npc, level_q};
      end else if (epc_wr) begin
        stk_q[top_idx].pc <= c0_wdata;
      end
    end
  end

endmodule

// File: tb/tb_intc_nested.sv
// Bench for intc_nested: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the controller.
module tb_intc_nested;

  localparam int unsigned NCH   = 3;
  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        rst;
  logic [2:0]  irq;
  logic        eret;
  logic [31:0] npc;
  logic        mtc0;
  logic        mfc0;
  logic [1:0]  c0_addr;
  logic [31:0] c0_wdata;

  logic [31:0] c0_rdata, entry, epc;
  logic        interrupt;
  logic [1:0]  level;
  logic [2:0]  pending;

  logic [31:0] s_c0_rdata, s_entry, s_epc;
  logic        s_interrupt;
  logic [1:0]  s_level;
  logic [2:0]  s_pending;

  int checks;
  int errors;

  intc_nested #(.NCH(NCH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .irq(irq), .eret(eret), .npc(npc),
    .mtc0(mtc0), .mfc0(mfc0), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_rdata(c0_rdata), .interrupt(interrupt), .entry(entry),
    .epc(epc), .level(level), .pending(pending)
  );

  intc_nested #(.NCH(NCH), .DEPTH(2)) dut_small (
    .clk(clk), .rst(rst), .irq(irq), .eret(eret), .npc(npc),
    .mtc0(mtc0), .mfc0(mfc0), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_rdata(s_c0_rdata), .interrupt(s_interrupt), .entry(s_entry),
    .epc(s_epc), .level(s_level), .pending(s_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    int          lvl;
  } frame_t;

  frame_t      stk[$];
  bit [2:0]    m_pend, m_irq_q, m_mask;
  bit          m_ie;
  int          m_level;
  int          m_cand;
  bit          m_int;
  logic [31:0] m_entry, m_rdata, m_epc;

  task automatic model_reset();
    stk.delete();
    m_pend = '0; m_irq_q = '0; m_mask = 3'b111; m_ie = 1'b1; m_level = 0;
  endtask

  task automatic model_comb();
    m_cand = -1;
    for (int ch = NCH - 1; ch >= 0; ch--)
      if (m_cand < 0 && m_pend[ch] && m_mask[ch]) m_cand = ch;
    m_int = (m_cand >= 0) && m_ie && (m_cand + 1 > m_level)
            && (stk.size() < DEPTH) && !eret && !rst;
    m_epc = (stk.size() > 0) ? stk[stk.size()-1].pc : 32'h0;
    if (m_int) m_entry = 32'h0cdc + 32'(m_cand) * 32'h31;
    else if (eret) m_entry = m_epc;
    else m_entry = 32'h0;
    m_rdata = 32'h0;
    if (mfc0) begin
      case (c0_addr)
        2'd0: m_rdata = m_epc;
        2'd1: m_rdata = {28'h0, m_mask, m_ie};
        2'd2: m_rdata = {29'h0, m_pend};
        default: m_rdata = 32'(stk.size() * 256 + m_level);
      endcase
    end
  endtask

  task automatic model_step();
    bit [2:0] rise;
    bit [2:0] clr;
    bit       moved;
    int       old_size;
    frame_t   f;
    if (rst) begin
      model_reset();
      m_irq_q = '0;
      return;
    end
    rise = irq & ~m_irq_q;
    clr = '0;
    moved = 1'b0;
    old_size = stk.size();
    if (m_int) begin
      f.pc = npc; f.lvl = m_level;
      stk.push_back(f);
      clr[m_cand] = 1'b1;
      m_level = m_cand + 1;
      moved = 1'b1;
    end else if (eret && old_size > 0) begin
      f = stk.pop_back();
      m_level = f.lvl;
      moved = 1'b1;
    end
    if (mtc0) begin
      case (c0_addr)
        2'd0: if (old_size > 0 && !moved) begin
          f = stk.pop_back(); f.pc = c0_wdata; stk.push_back(f);
        end
        2'd1: begin m_ie = c0_wdata[0]; m_mask = c0_wdata[3:1]; end
        2'd2: clr = clr | c0_wdata[2:0];
        default: ;
      endcase
    end
    m_pend = (m_pend & ~clr) | rise;
    m_irq_q = irq;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    eret = 1'b0; mtc0 = 1'b0; mfc0 = 1'b0; c0_addr = 2'd0; c0_wdata = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1; irq = '0; npc = '0; idle();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL rst_level got=%0d exp=0", level); end
    checks++; if (epc !== 32'h0) begin errors++; $display("FAIL rst_epc got=%h exp=0", epc); end
    checks++; if (pending !== 3'b000) begin errors++; $display("FAIL rst_pending got=%b exp=000", pending); end
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL rst_int got=%b exp=0", interrupt); end
    checks++; if (c0_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata_nosel got=%h exp=0", c0_rdata); end
    mfc0 = 1'b1; c0_addr = 2'd1; settle();
    checks++; if (c0_rdata !== 32'hF) begin errors++; $display("FAIL rst_status got=%h exp=f", c0_rdata); end
    idle();
  endtask

  task automatic test_single();
    do_reset();
    irq = 3'b001; tick();
    irq = 3'b000; npc = 32'h100; settle();
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL single_int got=%b exp=1", interrupt); end
    checks++; if (entry !== 32'h0cdc) begin errors++; $display("FAIL single_entry got=%h exp=0cdc", entry); end
    tick();
    checks++; if (level !== 2'd1) begin errors++; $display("FAIL single_level got=%0d exp=1", level); end
    checks++; if (epc !== 32'h100) begin errors++; $display("FAIL single_epc got=%h exp=100", epc); end
    checks++; if (pending !== 3'b000) begin errors++; $display("FAIL single_pending got=%b exp=000", pending); end
    eret = 1'b1; settle();
    checks++; if (entry !== 32'h100) begin errors++; $display("FAIL single_eret_entry got=%h exp=100", entry); end
    tick(); eret = 1'b0;
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL single_ret_level got=%0d exp=0", level); end
    checks++; if (epc !== 32'h0) begin errors++; $display("FAIL single_ret_epc got=%h exp=0", epc); end
  endtask

  task automatic test_nesting();
    do_reset();
    irq = 3'b001; tick();
    irq = 3'b000; npc = 32'h200; settle(); tick();
    irq = 3'b100; tick();
    irq = 3'b000; npc = 32'h204; settle();
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL nest_int got=%b exp=1", interrupt); end
    checks++; if (entry !== 32'h0d3e) begin errors++; $display("FAIL nest_entry got=%h exp=0d3e", entry); end
    tick();
    mfc0 = 1'b1; c0_addr = 2'd3; settle();
    checks++; if (level !== 2'd3) begin errors++; $display("FAIL nest_level got=%0d exp=3", level); end
    checks++; if (c0_rdata !== 32'h0000_0203) begin errors++; $display("FAIL nest_sp_level got=%h exp=00000203", c0_rdata); end
    mfc0 = 1'b0; eret = 1'b1; settle();
    checks++; if (entry !== 32'h204) begin errors++; $display("FAIL nest_eret1 got=%h exp=204", entry); end
    tick();
    checks++; if (level !== 2'd1) begin errors++; $display("FAIL nest_lvl1 got=%0d exp=1", level); end
    checks++; if (entry !== 32'h200) begin errors++; $display("FAIL nest_eret2 got=%h exp=200", entry); end
    tick(); eret = 1'b0;
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL nest_lvl0 got=%0d exp=0", level); end
  endtask

  task automatic test_priority_block();
    do_reset();
    irq = 3'b100; tick();
    irq = 3'b000; npc = 32'h300; settle(); tick();
    irq = 3'b010; tick();
    irq = 3'b000; settle();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL blk_int got=%b exp=0", interrupt); end
    checks++; if (pending !== 3'b010) begin errors++; $display("FAIL blk_pending got=%b exp=010", pending); end
    eret = 1'b1; settle();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL blk_eret_int got=%b exp=0", interrupt); end
    tick(); eret = 1'b0; settle();
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL blk_level got=%0d exp=0", level); end
    checks++; if (interrupt !== 1'b1 || entry !== 32'h0d0d) begin errors++; $display("FAIL blk_take got=%b/%h exp=1/0d0d", interrupt, entry); end
    tick();
    checks++; if (level !== 2'd2) begin errors++; $display("FAIL blk_level2 got=%0d exp=2", level); end
  endtask

  task automatic test_mask_ie();
    do_reset();
    mtc0 = 1'b1; c0_addr = 2'd1; c0_wdata = 32'h0; tick();
    mtc0 = 1'b0;
    irq = 3'b010; tick();
    irq = 3'b000; settle();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL ie0_int got=%b exp=0", interrupt); end
    checks++; if (pending !== 3'b010) begin errors++; $display("FAIL ie0_pending got=%b exp=010", pending); end
    mtc0 = 1'b1; c0_addr = 2'd1; c0_wdata = 32'hF; settle();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL ie_wr_same_cycle got=%b exp=0", interrupt); end
    tick();
    mtc0 = 1'b0; mfc0 = 1'b1; settle();
    checks++; if (c0_rdata !== 32'hF) begin errors++; $display("FAIL status_rd got=%h exp=f", c0_rdata); end
    checks++; if (interrupt !== 1'b1 || entry !== 32'h0d0d) begin errors++; $display("FAIL ie1_take got=%b/%h exp=1/0d0d", interrupt, entry); end
    tick(); idle();
    checks++; if (level !== 2'd2) begin errors++; $display("FAIL ie1_level got=%0d exp=2", level); end
  endtask

  task automatic test_stack_full();
    do_reset();
    irq = 3'b001; tick();
    irq = 3'b000; npc = 32'h500; settle(); tick();
    irq = 3'b010; tick();
    irq = 3'b000; npc = 32'h504; settle(); tick();
    irq = 3'b100; tick();
    irq = 3'b000; settle();
    checks++; if (s_level !== 2'd2) begin errors++; $display("FAIL full_level got=%0d exp=2", s_level); end
    checks++; if (s_interrupt !== 1'b0) begin errors++; $display("FAIL full_int got=%b exp=0", s_interrupt); end
    checks++; if (s_pending !== 3'b100) begin errors++; $display("FAIL full_pending got=%b exp=100", s_pending); end
    tick();
    checks++; if (s_interrupt !== 1'b0) begin errors++; $display("FAIL full_int2 got=%b exp=0", s_interrupt); end
    eret = 1'b1; settle();
    checks++; if (s_interrupt !== 1'b0 || s_entry !== 32'h504) begin errors++; $display("FAIL full_eret got=%b/%h exp=0/504", s_interrupt, s_entry); end
    tick(); eret = 1'b0; settle();
    checks++; if (s_level !== 2'd1) begin errors++; $display("FAIL full_pop_level got=%0d exp=1", s_level); end
    checks++; if (s_interrupt !== 1'b1 || s_entry !== 32'h0d3e) begin errors++; $display("FAIL full_take got=%b/%h exp=1/0d3e", s_interrupt, s_entry); end
    tick();
    checks++; if (s_level !== 2'd3) begin errors++; $display("FAIL full_take_level got=%0d exp=3", s_level); end
  endtask

  task automatic test_corners();
    // eret coincident with an eligible request
    do_reset();
    irq = 3'b001; tick();
    irq = 3'b000; npc = 32'h600; settle(); tick();
    irq = 3'b100; tick();
    irq = 3'b000; eret = 1'b1; settle();
    checks++; if (interrupt !== 1'b0 || entry !== 32'h600) begin errors++; $display("FAIL coinc_eret got=%b/%h exp=0/600", interrupt, entry); end
    tick(); eret = 1'b0; settle();
    checks++; if (interrupt !== 1'b1 || entry !== 32'h0d3e) begin errors++; $display("FAIL coinc_next got=%b/%h exp=1/0d3e", interrupt, entry); end
    tick();
    checks++; if (level !== 2'd3) begin errors++; $display("FAIL coinc_level got=%0d exp=3", level); end
    // eret with an empty stack
    do_reset();
    mtc0 = 1'b1; c0_addr = 2'd1; c0_wdata = 32'hE; tick();
    mtc0 = 1'b0; irq = 3'b010; tick();
    irq = 3'b000; eret = 1'b1; settle();
    checks++; if (entry !== 32'h0 || interrupt !== 1'b0) begin errors++; $display("FAIL empty_eret got=%b/%h exp=0/0", interrupt, entry); end
    tick(); eret = 1'b0; mfc0 = 1'b1; c0_addr = 2'd3; settle();
    checks++; if (c0_rdata !== 32'h0 || epc !== 32'h0) begin errors++; $display("FAIL empty_state got=%h/%h exp=0/0", c0_rdata, epc); end
    checks++; if (pending !== 3'b010) begin errors++; $display("FAIL empty_pending got=%b exp=010", pending); end
    idle();
    // reset in the middle of a nest
    do_reset();
    irq = 3'b001; tick();
    irq = 3'b000; npc = 32'h700; settle(); tick();
    irq = 3'b100; tick();
    irq = 3'b000; rst = 1'b1; settle();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL rst_mid_int got=%b exp=0", interrupt); end
    tick(); rst = 1'b0; mfc0 = 1'b1; c0_addr = 2'd3; settle();
    checks++; if (level !== 2'd0 || epc !== 32'h0 || pending !== 3'b000) begin errors++; $display("FAIL rst_mid_state got=%0d/%h/%b exp=0/0/000", level, epc, pending); end
    checks++; if (c0_rdata !== 32'h0) begin errors++; $display("FAIL rst_mid_sp got=%h exp=0", c0_rdata); end
    idle();
  endtask

  task automatic test_random();
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst  = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) irq = 3'($urandom);
      eret = ($urandom_range(0, 4) == 0);
      npc  = $urandom;
      mtc0 = ($urandom_range(0, 9) == 0);
      mfc0 = 1'($urandom);
      c0_addr  = 2'($urandom);
      c0_wdata = $urandom;
      if (c0_addr == 2'd1) c0_wdata[0] = ($urandom_range(0, 3) != 0);
      settle();
      model_comb();
      checks++; if (interrupt !== m_int) begin errors++; $display("FAIL rnd_int cyc=%0d got=%b exp=%b", cyc, interrupt, m_int); end
      checks++; if (entry !== m_entry) begin errors++; $display("FAIL rnd_entry cyc=%0d got=%h exp=%h", cyc, entry, m_entry); end
      checks++; if (c0_rdata !== m_rdata) begin errors++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, c0_rdata, m_rdata); end
      tick();
      model_step();
      m_epc = (stk.size() > 0) ? stk[stk.size()-1].pc : 32'h0;
      checks++; if (level !== 2'(m_level)) begin errors++; $display("FAIL rnd_level cyc=%0d got=%0d exp=%0d", cyc, level, m_level); end
      checks++; if (epc !== m_epc) begin errors++; $display("FAIL rnd_epc cyc=%0d got=%h exp=%h", cyc, epc, m_epc); end
      checks++; if (pending !== m_pend) begin errors++; $display("FAIL rnd_pending cyc=%0d got=%b exp=%b", cyc, pending, m_pend); end
    end
    rst = 1'b0; irq = '0; idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; irq = '0; npc = '0;
    idle();
    test_reset();
    test_single();
    test_nesting();
    test_priority_block();
    test_mask_ie();
    test_stack_full();
    test_corners();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/intc_nested.md
Name: intc_nested

Overview:
- Parametrised successor interrupt controller. N prioritised interrupt channels, true nesting with an EPC/level stack, per-channel masking and a global enable.
- Logically in WB: when an interrupt is taken, it redirects PC to a per-channel vector; `eret` pops the stack to return to the saved PC.
- CP0-style register file accessed via mfc0/mtc0.

Parameters:
- NCH, 3, number of interrupt channels; channel NCH-1 has highest priority.
- DEPTH, 4, nesting stack depth in entries. Must satisfy DEPTH ≤ NCH+1.
- ENTRY_BASE, 32'h0000_0cdc, vector address of channel 0.
- ENTRY_STRIDE, 32'h31, vector spacing: entry(ch) = ENTRY_BASE + ch*ENTRY_STRIDE.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- irq  in  NCH  raw interrupt requests; a rising edge sets the pending bit.
- eret  in  1  return from handler, one-cycle pulse.
- npc  in  32  PC to resume at if an interrupt is taken this cycle.
- mtc0  in  1  CP0 write strobe.
- mfc0  in  1  CP0 read select.
- c0_addr  in  2  CP0 register select.
- c0_wdata  in  32  CP0 write data.
- c0_rdata  out  32  CP0 read data, combinational; 0 when mfc0=0.
- interrupt  out  1  take-interrupt, combinational, this cycle.
- entry  out  32  redirect PC. Valid when interrupt or eret is high.
- epc  out  32  top-of-stack return PC; 0 when the stack is empty.
- level  out  $clog2(NCH+1)  current priority level; 0 means no handler is active.
- pending  out  NCH  pending request bits.

Behaviour:
- Reset (sync): pending=0, irq_q=0, stack empty (sp=0), level=0, ie=1, mask=all-ones (all enabled). All outputs 0 except c0_rdata per mfc0.
- Edge detect: irq_q<=irq every cycle. rise = irq & ~irq_q sets pending next cycle. Level-held irq does not re-set pending after it is cleared.
- Arbitration (combinational): cand = highest index ch with pending[ch] & mask[ch].
  - interrupt = cand exists & ie & (cand+1 > level) & (sp < DEPTH) & ~eret.
- Take (interrupt=1), at the clock edge:
  - push {npc, level}; sp+1.
  - level <= cand+1.
  - pending[cand] <= 0, unless a new rise on that channel arrives in the same cycle; then the bit stays 1.
  - entry = ENTRY_BASE + cand*ENTRY_STRIDE.
- Nesting: a higher-priority pending request preempts an active handler immediately (next eligible cycle). Equal or lower priority waits until level drops.
- eret, stack non-empty:
  - entry = epc (top).
  - At the edge: pop; level <= saved level; sp-1.
  - Pending requests stay latched. A request blocked during the handler can be taken the cycle after the pop.
- eret, stack empty: no state change; entry=0.
- eret and an eligible interrupt in the same cycle: eret wins; interrupt=0 that cycle. Re-evaluate next cycle.
- Stack full (sp=DEPTH): interrupt held 0 regardless of priority; requests stay pending.
- CP0 map:
  - 0 = EPC. Read returns top. mtc0 overwrites the top entry's PC only if sp>0, else ignored.
  - 1 = STATUS {mask[NCH-1:0] at bits NCH:1, ie at bit 0}, R/W.
  - 2 = PENDING. Read returns pending. Write-1-to-clear; a same-cycle rise wins over the clear.
  - 3 = {sp, level}, read-only, zero-extended; level in low bits, sp at bits 15:8.
- mtc0 to STATUS in the same cycle as a take: the take uses the old ie/mask; new values apply next cycle.
- rst mid-handler: stack, level and pending all cleared on that edge; interrupt=0 during rst.

Test Plan:
1. Reset, then a single pulse on irq[0] with npc=32'h100. Interrupt=1 one cycle after the edge registers pending; entry=32'h0cdc. Next cycle: level=1, epc=32'h100, pending=0. eret → entry=32'h100, then level=0, epc=0.
2. Nesting: take ch0 at npc=32'h200, then pulse irq[2] at npc=32'h204. Interrupt taken with entry=32'h0d3e, level=3, sp=2. First eret returns to 32'h204 with level=1; second eret returns to 32'h200 with level=0.
3. Priority block: inside ch2 handler (level=3), pulse irq[1]. interrupt stays 0 and pending=3'b010. eret → level=0; next cycle interrupt=1, entry=32'h0d0d.
4. Masking/ie: write STATUS=0 (ie=0), pulse irq[1]. No take; pending[1]=1. Write STATUS=32'hF (mask all, ie=1) → take next cycle.
5. Stack full with DEPTH=2, NCH=3: take ch0, then ch1, then pulse ch2. Interrupt stays 0 until an eret; the cycle after the pop, ch2 is taken.
6. Corners:
   - eret coincident with an eligible irq → interrupt=0 that cycle, taken the next.
   - eret with empty stack → level, sp and epc unchanged.
   - rst asserted mid-nest → sp=0, level=0, pending=0 on the next edge.
